// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: PC, req/ack read of instruction memory, IR and PC-of-IR.
// Optional build macro IFU_MISALIGN_EN traps fetches from a PC that is not word aligned.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_wr,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_old,
   output logic        fetch_done,
   output logic        fetch_busy,
   output logic        fetch_err,
   output logic        fetch_misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] pc_eff;
   logic        start_misalign;

   // A pc_wr in the same cycle as fetch_req redirects that very fetch.
   assign pc_eff = pc_wr ? pc_next : pc;

`ifdef IFU_MISALIGN_EN
   assign start_misalign = (pc_eff[1:0] != 2'b00);
   assign imem_addr      = pc;
`else
   assign start_misalign = 1'b0;
   assign imem_addr      = {pc[31:2], 2'b00};
`endif

   // NOTE: every register here is updated with <= so all of them see pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         pc_old         <= RESET_PC;
         instr          <= NOP;
         wait_cnt       <= '0;
         imem_req       <= 1'b0;
         fetch_done     <= 1'b0;
         fetch_busy     <= 1'b0;
         fetch_err      <= 1'b0;
         fetch_misalign <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         unique case (state)
            IDLE, ERR: begin
               pc <= pc_eff;
               if (fetch_req) begin
                  wait_cnt <= '0;
                  if (start_misalign) begin
                     state          <= ERR;
                     fetch_err      <= 1'b1;
                     fetch_misalign <= 1'b1;
                  end else begin
                     state          <= WAIT;
                     imem_req       <= 1'b1;
                     fetch_busy     <= 1'b1;
                     fetch_err      <= 1'b0;
                     fetch_misalign <= 1'b0;
                  end
               end
            end
            WAIT: begin
               // An ack in the final allowed cycle still completes the fetch.
               if (imem_ack) begin
                  instr      <= imem_rdata;
                  pc_old     <= pc;
                  pc         <= pc + 32'd4;
                  fetch_done <= 1'b1;
                  imem_req   <= 1'b0;
                  fetch_busy <= 1'b0;
                  state      <= IDLE;
               end else if (wait_cnt == TO_LAST) begin
                  imem_req   <= 1'b0;
                  fetch_busy <= 1'b0;
                  fetch_err  <= 1'b1;
                  state      <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetches against a
// transaction-level model of PC / IR / error status.
module tb_instr_fetch_unit;

   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic        pc_wr;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_old;
   logic        fetch_done;
   logic        fetch_busy;
   logic        fetch_err;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: architectural view after each completed transaction.
   logic [31:0] m_pc, m_pc_old, m_instr;
   logic        m_err, m_mis;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_wr(pc_wr), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .instr(instr), .pc(pc), .pc_old(pc_old), .fetch_done(fetch_done), .fetch_busy(fetch_busy),
      .fetch_err(fetch_err), .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit misaligned(input logic [31:0] p);
`ifdef IFU_MISALIGN_EN
      return p[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IFU_MISALIGN_EN
      return p;
`else
      return {p[31:2], 2'b00};
`endif
   endfunction

   task automatic check_arch(input string tag);
      check({tag, "_pc"}, pc, m_pc);
      check({tag, "_pc_old"}, pc_old, m_pc_old);
      check({tag, "_instr"}, instr, m_instr);
      check({tag, "_err"}, fetch_err, m_err);
      check({tag, "_mis"}, fetch_misalign, m_mis);
   endtask

   task automatic idle_tick();
      tick();
      check("idle_done", fetch_done, 1'b0);
      check("idle_req", imem_req, 1'b0);
      check("idle_busy", fetch_busy, 1'b0);
      check_arch("idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_pc = RESET_PC; m_pc_old = RESET_PC; m_instr = NOP; m_err = 1'b0; m_mis = 1'b0;
   endtask

   // One fetch transaction; ack arrives in WAIT cycle (delay+1). delay >= TIMEOUT means no ack.
   task automatic do_fetch(input bit use_wr, input logic [31:0] new_pc, input int delay,
                           input logic [31:0] rdata);
      logic [31:0] fpc;
      fpc = use_wr ? new_pc : m_pc;
      pc_wr = use_wr; pc_next = new_pc; fetch_req = 1'b1;
      tick();
      pc_wr = 1'b0; fetch_req = 1'b0; pc_next = $urandom;
      m_pc = fpc;
      check("start_done", fetch_done, 1'b0);
      if (misaligned(fpc)) begin
         m_err = 1'b1; m_mis = 1'b1;
         check("mis_req", imem_req, 1'b0);
         check("mis_busy", fetch_busy, 1'b0);
         check_arch("mis");
         return;
      end
      m_err = 1'b0; m_mis = 1'b0;
      check("start_err", fetch_err, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) begin
         check("wait_req", imem_req, 1'b1);
         check("wait_busy", fetch_busy, 1'b1);
         check("wait_addr", imem_addr, exp_addr(m_pc));
         if (i == delay) begin
            imem_ack = 1'b1; imem_rdata = rdata;
            tick();
            imem_ack = 1'b0; imem_rdata = $urandom;
            m_pc_old = m_pc; m_pc = m_pc + 32'd4; m_instr = rdata;
            check("ack_done", fetch_done, 1'b1);
            check("ack_req", imem_req, 1'b0);
            check_arch("ack");
            return;
         end
         tick();
         check("wait_done", fetch_done, 1'b0);
      end
      m_err = 1'b1;
      check("to_req", imem_req, 1'b0);
      check("to_busy", fetch_busy, 1'b0);
      check_arch("to");
   endtask

   initial begin
      logic [31:0] rpc;
      rst = 1'b1; fetch_req = 1'b0; pc_wr = 1'b0; pc_next = '0; imem_ack = 1'b0; imem_rdata = '0;

      do_reset();
      check("rst_req", imem_req, 1'b0);
      check("rst_busy", fetch_busy, 1'b0);
      check("rst_done", fetch_done, 1'b0);
      check_arch("rst");

      // First fetch from reset PC, ack in the first WAIT cycle.
      do_fetch(1'b0, 32'h0, 0, 32'h0050_0093);
      idle_tick();

      // Redirect and fetch in the same cycle, ack in the 4th WAIT cycle.
      do_fetch(1'b1, 32'h0000_0100, 3, 32'hDEAD_BEEF);
      idle_tick();

      // No ack: timeout, error held, then recovery.
      do_fetch(1'b0, 32'h0, TIMEOUT + 5, 32'h0);
      idle_tick();
      idle_tick();
      do_fetch(1'b0, 32'h0, 2, 32'h1234_5678);

      // Ack exactly in the last allowed WAIT cycle wins over the timeout.
      do_fetch(1'b0, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D);
      idle_tick();

      // PC wrap.
      do_fetch(1'b1, 32'hFFFF_FFFC, 1, 32'hCAFE_0001);
      check("wrap_pc", pc, 32'h0);

      // Back-to-back: next request issued in the fetch_done cycle.
      do_fetch(1'b0, 32'h0, 0, 32'h1111_1111);
      do_fetch(1'b0, 32'h0, 1, 32'h2222_2222);
      idle_tick();

      // Reset mid-WAIT, late ack must be ignored.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = RESET_PC; m_pc_old = RESET_PC; m_instr = NOP; m_err = 1'b0; m_mis = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
      tick();
      imem_ack = 1'b0;
      check("rstw_done", fetch_done, 1'b0);
      check("rstw_req", imem_req, 1'b0);
      check_arch("rstw");
      idle_tick();

      // Misaligned target.
      do_fetch(1'b1, 32'h0000_0102, 0, 32'h3333_3333);
      idle_tick();

      // Randomized transactions.
      for (int n = 0; n < 30; n++) begin
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         do_fetch(1'($urandom_range(0, 1)), rpc, int'($urandom_range(0, TIMEOUT + 3)), $urandom);
         if ($urandom_range(0, 1) == 1) idle_tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
